// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer and its return stack.
// Contents:
//   OPCODE_W      opcode field width of a program word
//   OPERAND_LSB   operand field position (LSB-aligned in the word)
//   instruction_t ICU opcode set (opcode field sits MSB-aligned above the operand)
//   ST_RUN/ST_HALT sequencer FSM state constants
package program_sequencer_pkg;

  localparam int OPCODE_W    = 4;
  localparam int OPERAND_LSB = 0;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOPO = 4'h0,
    OP_LD   = 4'h1,
    OP_LDC  = 4'h2,
    OP_AND  = 4'h3,
    OP_ANDC = 4'h4,
    OP_OR   = 4'h5,
    OP_ORC  = 4'h6,
    OP_XNOR = 4'h7,
    OP_STO  = 4'h8,
    OP_STOC = 4'h9,
    OP_IEN  = 4'hA,
    OP_OEN  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RTN  = 4'hD,
    OP_SKZ  = 4'hE,
    OP_NOPF = 4'hF
  } instruction_t;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  // Opcode LSB position for a given operand width (opcode is MSB-aligned).
  function automatic int opcode_lsb(input int addr_w);
    return addr_w;
  endfunction

endpackage

// File: rtl/program_sequencer_return_stack.sv
// LIFO of return addresses for subroutine calls.
// Ports:
//   clk, rst   clock and synchronous active-low reset (clears occupancy only)
//   push, pop  requests; push wins if both are raised in the same cycle
//   din        address to push
//   dout       top-of-stack entry (zero when empty), combinational
//   sp         number of valid entries, 0..DEPTH
//   overflow   push requested while full; the push is dropped
//   underflow  pop requested while empty; nothing changes
module return_stack
  import program_sequencer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  localparam int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic [SP_W-1:0]   sp,
  output logic              overflow,
  output logic              underflow
);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic              full;
  logic              empty;

  assign full      = (sp == SP_W'(DEPTH));
  assign empty     = (sp == '0);
  assign overflow  = push & full;
  assign underflow = pop & ~push & empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sp <= '0;
    end else if (push) begin
      if (!full) sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

  // Entry i is written when sp==i, i.e. it becomes the new top.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && !full && (sp == SP_W'(i))) mem[i] <= din;
    end
  end

  // Top of stack lives at index sp-1; a compare loop avoids an
  // out-of-range index when the stack is empty.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp == SP_W'(i + 1)) dout = mem[i];
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Fetch/sequencing stage feeding the ICU.
// Holds the PC (driven out as the ROM address), splits the fetched word into
// opcode (to the ICU) and operand (to the I/O decoder), and reacts to the
// ICU's decoded flags: JMP (with call when preceded by NOPO), RTN through a
// return stack, NOPF halt and resume on run.
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   prog_addr    ROM address (= PC)
//   prog_data    asynchronous ROM word {opcode, operand}
//   instruction  opcode field, combinational
//   io_addr      operand field, combinational
//   jmp, rtn, flag_o, flag_f  ICU flags for the word currently at the PC
//   rr_in        ICU result register, used by SKZ shadowing
//   run          resume request while halted
//   halted       high in HALT state (this is the FSM state output)
//   stack_err    sticky return-stack overflow/underflow
//   sp           return-stack occupancy
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [ADDR_W-1:0]            prog_addr,
  input  logic [OPCODE_W+ADDR_W-1:0]   prog_data,
  output instruction_t                 instruction,
  output logic [ADDR_W-1:0]            io_addr,
  input  logic                         jmp,
  input  logic                         rtn,
  input  logic                         flag_o,
  input  logic                         flag_f,
  input  logic                         rr_in,
  input  logic                         run,
  output logic                         halted,
  output logic                         stack_err,
  output logic [$clog2(DEPTH+1)-1:0]   sp
);

  localparam int OPCODE_LSB = opcode_lsb(ADDR_W);

  logic [ADDR_W-1:0] pc, pc_next, pc_inc;
  logic [0:0]        state, state_next;
  logic              skip_q, call_q;
  logic              acc, skip_d;
  logic              take_halt, take_jmp, take_rtn;
  logic              stk_push, stk_pop;
  logic [ADDR_W-1:0] stk_dout;
  logic              stk_overflow, stk_underflow;

  assign prog_addr   = pc;
  assign instruction = instruction_t'(prog_data[OPCODE_LSB +: OPCODE_W]);
  assign io_addr     = prog_data[OPERAND_LSB +: ADDR_W];
  assign halted      = (state == ST_HALT);
  assign pc_inc      = pc + ADDR_W'(1);

  // Flags describe the word at the PC; they are acted on only when that
  // word is live: running, and not the word the ICU is skipping.
  assign acc       = (state == ST_RUN) && !skip_q;
  assign take_halt = acc && flag_f;
  assign take_jmp  = acc && !flag_f && jmp;
  assign take_rtn  = acc && !flag_f && !jmp && rtn;
  assign stk_push  = take_jmp && call_q;
  assign stk_pop   = take_rtn;

  // The ICU skips the word after RTN and after SKZ with rr==0; mirror it.
  assign skip_d = acc && ((instruction == OP_RTN) ||
                          ((instruction == OP_SKZ) && !rr_in));

  always_comb begin
    pc_next    = pc_inc;
    state_next = state;
    if (state == ST_HALT) begin
      pc_next = run ? pc_inc : pc;
      if (run) state_next = ST_RUN;
    end else if (take_halt) begin
      pc_next    = pc;
      state_next = ST_HALT;
    end else if (take_jmp) begin
      pc_next = io_addr;
    end else if (take_rtn) begin
      // An empty-stack return just falls through to the next word.
      pc_next = stk_underflow ? pc_inc : stk_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc        <= '0;
      state     <= ST_RUN;
      skip_q    <= 1'b0;
      call_q    <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      pc        <= pc_next;
      state     <= state_next;
      skip_q    <= skip_d;
      call_q    <= acc && flag_o;
      stack_err <= stack_err | stk_overflow | stk_underflow;
    end
  end

  return_stack #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_return_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (stk_push),
    .pop       (stk_pop),
    .din       (pc_inc),
    .dout      (stk_dout),
    .sp        (sp),
    .overflow  (stk_overflow),
    .underflow (stk_underflow)
  );

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: a ROM array, a small ICU flag decoder that
// latches the word at negedge, an instruction-level reference interpreter,
// directed scenarios with literal expectations, and randomized programs.
module tb_program_sequencer;
  import program_sequencer_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int SP_W   = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [ADDR_W-1:0]   prog_addr;
  logic [ADDR_W+3:0]   prog_data;
  instruction_t        instruction;
  logic [ADDR_W-1:0]   io_addr;
  logic                jmp, rtn, flag_o, flag_f;
  logic                rr_in = 1'b0;
  logic                run = 1'b0;
  logic                halted, stack_err;
  logic [SP_W-1:0]     sp;

  logic [ADDR_W+3:0]   rom [256];
  assign prog_data = rom[prog_addr];

  program_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .instruction (instruction),
    .io_addr     (io_addr),
    .jmp         (jmp),
    .rtn         (rtn),
    .flag_o      (flag_o),
    .flag_f      (flag_f),
    .rr_in       (rr_in),
    .run         (run),
    .halted      (halted),
    .stack_err   (stack_err),
    .sp          (sp)
  );

  // ICU stand-in: latch the presented word at negedge, decode flags.
  logic [3:0] icu_op = 4'h1;
  always @(negedge clk) icu_op <= prog_data[ADDR_W+3:ADDR_W];
  assign jmp    = (icu_op == 4'hC);
  assign rtn    = (icu_op == 4'hD);
  assign flag_o = (icu_op == 4'h0);
  assign flag_f = (icu_op == 4'hF);

  // ---------------- scoreboard counters ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference interpreter ----------------
  // One step per clock: executes the word at the model PC as the ICU+sequencer
  // pair would, with the return stack kept as a queue.
  logic [ADDR_W-1:0] m_pc = '0;
  bit                m_halted = 0, m_skip = 0, m_call = 0, m_err = 0;
  logic [ADDR_W-1:0] m_stack[$];

  always @(posedge clk) begin
    logic [3:0]        op;
    logic [ADDR_W-1:0] opd, ret;
    bit                live, nskip, ncall;
    if (!rst) begin
      m_pc = '0; m_halted = 0; m_skip = 0; m_call = 0; m_err = 0;
      m_stack.delete();
    end else begin
      op    = rom[m_pc][ADDR_W+3:ADDR_W];
      opd   = rom[m_pc][ADDR_W-1:0];
      live  = !m_halted && !m_skip;
      nskip = live && (op == 4'hD || (op == 4'hE && !rr_in));
      ncall = live && (op == 4'h0);
      if (m_halted) begin
        if (run) begin m_pc = m_pc + 1'b1; m_halted = 0; end
      end else if (!live) begin
        m_pc = m_pc + 1'b1;
      end else if (op == 4'hF) begin
        m_halted = 1;
      end else if (op == 4'hC) begin
        if (m_call) begin
          ret = m_pc + 1'b1;
          if (m_stack.size() == DEPTH) m_err = 1;
          else m_stack.push_back(ret);
        end
        m_pc = opd;
      end else if (op == 4'hD) begin
        if (m_stack.size() == 0) begin m_err = 1; m_pc = m_pc + 1'b1; end
        else m_pc = m_stack.pop_back();
      end else begin
        m_pc = m_pc + 1'b1;
      end
      m_skip = nskip;
      m_call = ncall;
    end
  end

  // Per-cycle compare against the interpreter, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc",        32'(prog_addr), 32'(m_pc));
      check("halted",    32'(halted),    32'(m_halted));
      check("stack_err", 32'(stack_err), 32'(m_err));
      check("sp",        32'(sp),        32'(m_stack.size()));
      check("opcode",    32'(instruction), 32'(rom[m_pc][ADDR_W+3:ADDR_W]));
      check("io_addr",   32'(io_addr),   32'(rom[m_pc][ADDR_W-1:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Enter reset and fill ROM with LD words (no flags, no skip).
  task automatic begin_load();
    rst = 1'b0;
    tick();
    chk_en = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = {4'h1, 8'(i)};
  endtask

  // Let the ICU latch the new word 0, then leave reset.
  task automatic end_load();
    ticks(2);
    chk_en = 1'b1;
    rst    = 1'b1;
  endtask

  task automatic put(input int addr, input logic [3:0] op, input logic [7:0] opd);
    rom[addr] = {op, opd};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state and free run through the whole address space.
    begin_load();
    end_load();
    rst = 1'b0;
    tick();
    check("rst_pc",     32'(prog_addr), 32'h0);
    check("rst_sp",     32'(sp),        32'h0);
    check("rst_halted", 32'(halted),    32'h0);
    check("rst_err",    32'(stack_err), 32'h0);
    rst = 1'b1;
    for (int j = 1; j <= 256; j++) begin
      tick();
      check("freerun_pc", 32'(prog_addr), 32'(j % 256));
    end
    check("freerun_err",    32'(stack_err), 32'h0);
    check("freerun_halted", 32'(halted),    32'h0);

    // Plain jump, no preceding NOPO.
    begin_load();
    put(5, 4'hC, 8'h40);
    end_load();
    ticks(4); check("jmp_pc4", 32'(prog_addr), 32'h04);
    tick();   check("jmp_pc5", 32'(prog_addr), 32'h05);
    tick();   check("jmp_pc40", 32'(prog_addr), 32'h40);
              check("jmp_sp",  32'(sp), 32'h0);
    tick();   check("jmp_pc41", 32'(prog_addr), 32'h41);

    // Call and return; the JMP at the return address must be ignored.
    begin_load();
    put(10, 4'h0, 8'h00);
    put(11, 4'hC, 8'h80);
    put(8'h82, 4'hD, 8'h00);
    put(12, 4'hC, 8'h20);
    end_load();
    ticks(12); check("call_pc",  32'(prog_addr), 32'h80);
               check("call_sp",  32'(sp), 32'h1);
    ticks(3);  check("ret_pc",   32'(prog_addr), 32'h0C);
               check("ret_sp",   32'(sp), 32'h0);
    tick();    check("ret_skip", 32'(prog_addr), 32'h0D);

    // SKZ with rr=0 skips the JMP; with rr=1 the JMP is taken.
    for (int r = 0; r < 2; r++) begin
      begin_load();
      put(3, 4'hE, 8'h00);
      put(4, 4'hC, 8'h30);
      rr_in = r[0];
      end_load();
      ticks(5);
      check("skz_pc", 32'(prog_addr), (r == 0) ? 32'h05 : 32'h30);
    end
    rr_in = 1'b0;

    // Halt on NOPF, hold, resume on run.
    begin_load();
    put(7, 4'hF, 8'h00);
    end_load();
    ticks(8);
    check("halt_pc", 32'(prog_addr), 32'h07);
    check("halt_st", 32'(halted),    32'h1);
    for (int j = 0; j < 10; j++) begin
      tick();
      check("hold_pc", 32'(prog_addr), 32'h07);
    end
    run = 1'b1;
    tick();
    run = 1'b0;
    check("resume_pc", 32'(prog_addr), 32'h08);
    check("resume_st", 32'(halted),    32'h0);

    // Five nested calls then five returns: overflow, then underflow.
    begin_load();
    put(1, 4'h0, 8'h00);    put(2, 4'hC, 8'h10);
    put(8'h10, 4'h0, 8'h00); put(8'h11, 4'hC, 8'h20);
    put(8'h20, 4'h0, 8'h00); put(8'h21, 4'hC, 8'h30);
    put(8'h30, 4'h0, 8'h00); put(8'h31, 4'hC, 8'h40);
    put(8'h40, 4'h0, 8'h00); put(8'h41, 4'hC, 8'h50);
    put(8'h50, 4'hD, 8'h00);
    put(8'h33, 4'hD, 8'h00);
    put(8'h23, 4'hD, 8'h00);
    put(8'h13, 4'hD, 8'h00);
    put(4, 4'hD, 8'h00);
    end_load();
    ticks(10); check("nest_err0", 32'(stack_err), 32'h0);
               check("nest_sp4",  32'(sp), 32'h4);
    tick();    check("ovf_pc",    32'(prog_addr), 32'h50);
               check("ovf_sp",    32'(sp), 32'h4);
               check("ovf_err",   32'(stack_err), 32'h1);
    tick();    check("pop1_pc",   32'(prog_addr), 32'h32);
    ticks(8);  check("unf_pc",    32'(prog_addr), 32'h05);
               check("unf_sp",    32'(sp), 32'h0);
               check("unf_err",   32'(stack_err), 32'h1);
    rst = 1'b0;
    tick();
    check("clr_pc",     32'(prog_addr), 32'h0);
    check("clr_sp",     32'(sp),        32'h0);
    check("clr_err",    32'(stack_err), 32'h0);
    check("clr_halted", 32'(halted),    32'h0);

    // Randomized programs with random rr/run and occasional reset.
    for (int p = 0; p < 3; p++) begin
      begin_load();
      for (int i = 0; i < 256; i++)
        rom[i] = {4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
      end_load();
      for (int c = 0; c < 1500; c++) begin
        rr_in = 1'($urandom_range(0, 1));
        run   = ($urandom_range(0, 3) == 0);
        rst   = ($urandom_range(0, 399) != 0);
        tick();
      end
      rst = 1'b1;
      run = 1'b0;
    end

    chk_en = 1'b0;
    tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (checks %0d/%0d)", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Fetch/sequencing stage directly upstream of the ICU.
- Holds the program counter (PC) and drives the program ROM address.
- Splits each fetched word into the opcode sent to the ICU and the operand sent to the I/O address decoder.
- Consumes the ICU's jmp/rtn/flag_o/flag_f/rr_out to implement jumps, subroutine call/return through a return stack, and halt/resume.

Parameters:
- ADDR_W, 8, PC/operand width; program space is 2**ADDR_W words.
- DEPTH, 4, return-stack entries.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- prog_addr  out  ADDR_W  ROM address; equals the PC register.
- prog_data  in  4+ADDR_W  asynchronous ROM word. Bits [ADDR_W+3:ADDR_W] are the opcode; bits [ADDR_W-1:0] are the operand.
- instruction  out  instruction_t  opcode field of prog_data, combinational, to the ICU.
- io_addr  out  ADDR_W  operand field of prog_data, combinational.
- jmp, rtn, flag_o, flag_f  in  1 each  ICU decoded-instruction flags.
- rr_in  in  1  ICU result register (rr_out).
- run  in  1  resume request while halted.
- halted  out  1  high in HALT state.
- stack_err  out  1  sticky return-stack over/underflow.
- sp  out  $clog2(DEPTH+1)  stack occupancy.

Behaviour:
- Reset (rst=0 at posedge): pc=0, sp=0, state=RUN, skip_q=0, call_q=0, stack_err=0, halted=0. Reset mid-operation discards stack contents and pending state.
- Timing: word at PC is presented during cycle k. The ICU latches it at the following negedge. Its flags are sampled here at posedge k+1, while prog_data still shows the same word.
- Accept qualifier: acc = (state==RUN) & !skip_q. Flags are ignored when acc=0.
- skip_q: shadows the ICU skip.
  - Set at posedge when acc and opcode(prog_data)==RTN, or when acc and opcode==SKZ and rr_in==0.
  - Cleared at the next posedge unconditionally; it never chains.
  - rr_in is sampled at that same posedge.
- call_q <= acc & flag_o. A call is exactly NOPO immediately followed by JMP.
- RUN state, priority per posedge:
  1. acc & flag_f: PC holds; state -> HALT.
  2. acc & jmp: PC <= operand(prog_data). If call_q is set, push PC+1 first.
  3. acc & rtn: PC <= pop.
  4. Otherwise: PC <= PC+1.
- HALT state:
  - PC holds; the ICU re-latches NOPF every cycle and those flags are ignored.
  - run=1: PC <= PC+1; state -> RUN.
- Push when sp==DEPTH (overflow): push dropped; jump still taken; stack_err <= 1.
- Pop when sp==0 (underflow): PC <= PC+1; sp stays 0; stack_err <= 1.
- stack_err clears only on reset.
- PC arithmetic wraps modulo 2**ADDR_W; a pushed PC+1 wraps identically.
- jmp and rtn are mutually exclusive by construction; if both are asserted, jmp wins.
- The instruction at a return address is skipped by the ICU; skip_q makes the sequencer ignore its flags as well.

Decomposition:
- Shared instructions package: instruction_t/opcode enum, plus OPCODE_W=4 and word-field position constants (opcode MSB-aligned, operand LSB-aligned).
- Sub-module return_stack (LIFO):
  - Parameters: DEPTH, ADDR_W.
  - Ports: push, pop, din, dout, sp, overflow, underflow.
  - The same rst/clk as the sequencer.

Test Plan:
- Reset then free run over ROM of NOPs (ADDR_W=8): prog_addr goes 0,1,2,…,255,0. halted=0, stack_err=0.
- JMP 0x40 at address 5 (no preceding NOPO): PC sequence 4,5,0x40,0x41. sp stays 0.
- NOPO@10, JMP 0x80@11, then RTN@0x82: sp=1 with entry 12 after the jump; PC returns to 12 and sp=0. Flags of the word at 12 are ignored (place JMP 0x20 at 12 and confirm it is not taken); PC reaches 13.
- rr=0 and SKZ@3, with JMP 0x30@4: jump is ignored and PC reaches 5. Repeat with rr=1: PC becomes 0x30.
- NOPF@7: halted=1 and PC stays 7 for 10 cycles. Pulse run: PC=8, halted=0.
- DEPTH=4 with five nested calls: the fifth push is dropped and stack_err=1. Subsequent RTNs return four times; the fifth RTN advances PC+1 with stack_err still 1. Assert rst=0: all state is cleared.
